// File: rtl/mem_bus_arbiter.sv
// N-master to single-slave memory bus arbiter: fixed-priority or round-robin,
// grant held from selection until the slave acks, one idle cycle between grants.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 16,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_MASTERS-1:0]               m_access,
    output logic [NUM_MASTERS-1:0]               m_ack,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_data_out,
    input  logic [NUM_MASTERS-1:0]               m_wr_en,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_bytesel,
    input  logic [NUM_MASTERS-1:0]               m_io,
    output logic [DATA_WIDTH-1:0]                m_data_in,
    output logic                                 s_access,
    input  logic                                 s_ack,
    output logic [ADDR_WIDTH-1:0]                s_addr,
    output logic [DATA_WIDTH-1:0]                s_data_out,
    output logic                                 s_wr_en,
    output logic [DATA_WIDTH/8-1:0]              s_bytesel,
    output logic                                 s_io,
    input  logic [DATA_WIDTH-1:0]                s_data_in,
    output logic [$clog2(NUM_MASTERS)-1:0]       grant
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic          busy;

    // First requester found scanning upward from start, wrapping modulo NUM_MASTERS.
    function automatic logic [GW-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                           input logic [GW-1:0] start);
        logic [GW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(start) + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
        return win;
    endfunction

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|m_access) begin
                    grant_d = pick(m_access, ROUND_ROBIN ? ptr_q : '0);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ack) begin
                    state_d = IDLE;
                    if (ROUND_ROBIN)
                        ptr_d = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the slave-side request and ack so an aborted transfer never completes.
    always_comb begin
        busy       = (state_q == BUSY) && !reset;
        m_ack      = '0;
        if (busy && s_ack)
            m_ack[grant_q] = 1'b1;
        s_access   = busy;
        s_addr     = busy ? m_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        s_data_out = busy ? m_data_out[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        s_wr_en    = busy & m_wr_en[grant_q];
        s_bytesel  = busy ? m_bytesel[grant_q*BW +: BW] : '0;
        s_io       = busy & m_io[grant_q];
        m_data_in  = s_data_in;
        grant      = grant_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    a_hold_access: assert property (@(posedge clk) disable iff (reset)
        (state_q == BUSY) |-> m_access[grant_q]);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a 2-master fixed-priority instance and a 4-master
// round-robin instance, each compared every cycle against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // unit a: 2 masters, fixed priority
    logic [1:0]      a_acc, a_mack, a_we, a_io;
    logic [2*AW-1:0] a_addr;
    logic [2*DW-1:0] a_wd;
    logic [2*BW-1:0] a_bs;
    logic [DW-1:0]   a_mdin, a_sdout, a_sdin;
    logic            a_sacc, a_sack, a_swe, a_sio;
    logic [AW-1:0]   a_saddr;
    logic [BW-1:0]   a_sbs;
    logic [0:0]      a_grant;

    // unit b: 4 masters, round robin
    logic [3:0]      b_acc, b_mack, b_we, b_io;
    logic [4*AW-1:0] b_addr;
    logic [4*DW-1:0] b_wd;
    logic [4*BW-1:0] b_bs;
    logic [DW-1:0]   b_mdin, b_sdout, b_sdin;
    logic            b_sacc, b_sack, b_swe, b_sio;
    logic [AW-1:0]   b_saddr;
    logic [BW-1:0]   b_sbs;
    logic [1:0]      b_grant;

    mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1'b0)) dut_a (
        .clk(clk), .reset(reset), .m_access(a_acc), .m_ack(a_mack), .m_addr(a_addr),
        .m_data_out(a_wd), .m_wr_en(a_we), .m_bytesel(a_bs), .m_io(a_io), .m_data_in(a_mdin),
        .s_access(a_sacc), .s_ack(a_sack), .s_addr(a_saddr), .s_data_out(a_sdout),
        .s_wr_en(a_swe), .s_bytesel(a_sbs), .s_io(a_sio), .s_data_in(a_sdin), .grant(a_grant));

    mem_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .m_access(b_acc), .m_ack(b_mack), .m_addr(b_addr),
        .m_data_out(b_wd), .m_wr_en(b_we), .m_bytesel(b_bs), .m_io(b_io), .m_data_in(b_mdin),
        .s_access(b_sacc), .s_ack(b_sack), .s_addr(b_saddr), .s_data_out(b_sdout),
        .s_wr_en(b_swe), .s_bytesel(b_sbs), .s_io(b_sio), .s_data_in(b_sdin), .grant(b_grant));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: owner = -1 when no transfer is in flight, else the index being served.
    int own[2]   = '{-1, -1};
    int lastg[2] = '{0, 0};
    int ptr[2]   = '{0, 0};

    function automatic int pick(int n, bit rr, int p, logic [3:0] acc);
        for (int k = 0; k < n; k++) begin
            int i;
            i = rr ? (p + k) % n : k;
            if (acc[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int n, w;
            bit rr;
            logic [3:0] acc;
            logic sack;
            n    = (u == 0) ? 2 : 4;
            rr   = (u == 1);
            acc  = (u == 0) ? {2'b00, a_acc} : b_acc;
            sack = (u == 0) ? a_sack : b_sack;
            if (reset) begin
                own[u]   <= -1;
                lastg[u] <= 0;
                ptr[u]   <= 0;
            end else if (own[u] < 0) begin
                w = pick(n, rr, ptr[u], acc);
                if (w >= 0) begin
                    own[u]   <= w;
                    lastg[u] <= w;
                end
            end else if (sack) begin
                own[u] <= -1;
                if (rr) ptr[u] <= (own[u] + 1) % n;
            end
        end
    end

    function automatic logic [61:0] tup(logic sa, logic [3:0] ma, logic [AW-1:0] ad,
                                        logic [DW-1:0] dd, logic we, logic [1:0] bs,
                                        logic io, logic [1:0] g, logic [DW-1:0] md);
        return {sa, ma, ad, dd, we, bs, io, g, md};
    endfunction

    always @(negedge clk) begin
        int o;
        logic bz;
        o  = own[0];
        bz = (o >= 0) && !reset;
        if (o < 0) o = 0;
        chk("unit_a_cycle",
            tup(a_sacc, {2'b00, a_mack}, a_saddr, a_sdout, a_swe, a_sbs, a_sio, {1'b0, a_grant}, a_mdin),
            tup(bz, (bz && a_sack) ? (4'b0001 << o) : 4'b0000, bz ? a_addr[o*AW +: AW] : '0,
                bz ? a_wd[o*DW +: DW] : '0, bz & a_we[o], bz ? a_bs[o*BW +: BW] : '0,
                bz & a_io[o], 2'(lastg[0]), a_sdin));
        o  = own[1];
        bz = (o >= 0) && !reset;
        if (o < 0) o = 0;
        chk("unit_b_cycle",
            tup(b_sacc, b_mack, b_saddr, b_sdout, b_swe, b_sbs, b_sio, b_grant, b_mdin),
            tup(bz, (bz && b_sack) ? (4'b0001 << o) : 4'b0000, bz ? b_addr[o*AW +: AW] : '0,
                bz ? b_wd[o*DW +: DW] : '0, bz & b_we[o], bz ? b_bs[o*BW +: BW] : '0,
                bz & b_io[o], 2'(lastg[1]), b_sdin));
    end

    initial begin
        int c0, c1;
        logic [8:0] pat;
        logic [9:0] gseq;
        reset = 1'b1;
        a_acc = 2'b11; a_we = '0; a_io = '0; a_addr = '0; a_wd = '0; a_bs = '0;
        a_sack = 1'b0; a_sdin = 16'h0F0F;
        b_acc = 4'hF; b_we = 4'b0101; b_io = 4'b1010; b_sack = 1'b0; b_sdin = 16'h3C3C;
        for (int m = 0; m < 4; m++) begin
            b_addr[m*AW +: AW] = AW'(32'h10000 * (m + 1) + m);
            b_wd[m*DW +: DW]   = DW'(16'h1111 * (m + 1));
            b_bs[m*BW +: BW]   = BW'(m);
        end

        // reset held with every master requesting
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_s_access", a_sacc, 1'b0);
            chk("rst_m_ack", a_mack, 2'b00);
            chk("rst_grant", a_grant, 1'b0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", a_sacc, 1'b0);
        tick();
        @(negedge clk);
        chk("post_rst_access", {a_sacc, a_grant, b_sacc, b_grant}, 5'b1_0_1_00);
        tick();
        reset = 1'b1; a_acc = '0; b_acc = '0;
        tick();
        reset = 1'b0;

        // single master read, ack on the third busy cycle
        a_addr[0 +: AW] = 19'h00555;
        a_addr[AW +: AW] = 19'h01234;
        a_acc = 2'b10;
        tick(); tick(); tick();
        a_sack = 1'b1; a_sdin = 16'hBEEF;
        @(negedge clk);
        chk("single_addr", a_saddr, 19'h01234);
        chk("single_ack", a_mack, 2'b10);
        chk("single_rdata", a_mdin, 16'hBEEF);
        chk("single_wr_en", a_swe, 1'b0);
        tick();
        a_sack = 1'b0; a_acc = 2'b00;
        @(negedge clk);
        chk("single_done", {a_sacc, a_mack}, 3'b000);

        // fixed priority: master 1 starves while master 0 keeps requesting
        a_addr[0 +: AW] = 19'h00100;
        a_addr[AW +: AW] = 19'h00200;
        a_acc = 2'b11; a_sack = 1'b1;
        c0 = 0; c1 = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            if (a_mack[0]) c0++;
            if (a_mack[1]) c1++;
        end
        chk("fixed_m0_acks", 64'(c0), 64'd3);
        chk("fixed_m1_acks", 64'(c1), 64'd0);
        a_acc = 2'b10;
        tick();
        @(negedge clk);
        chk("fixed_m1_after_drop", {a_grant, a_mack}, 3'b1_10);
        tick();
        a_acc = 2'b00; a_sack = 1'b0;

        // write passthrough from master 0, master 1 fields deliberately different
        a_addr[0 +: AW] = 19'h7FFFF; a_wd[0 +: DW] = 16'hA55A; a_bs[0 +: BW] = 2'b01;
        a_we = 2'b01; a_io = 2'b01;
        a_addr[AW +: AW] = 19'h00003; a_wd[DW +: DW] = 16'h1111; a_bs[BW +: BW] = 2'b10;
        a_acc = 2'b01;
        tick();
        @(negedge clk);
        chk("wr_addr", a_saddr, 19'h7FFFF);
        chk("wr_data", a_sdout, 16'hA55A);
        chk("wr_ctrl", {a_swe, a_sbs, a_sio}, 4'b1_01_1);
        a_sack = 1'b1;
        tick();
        a_acc = 2'b00; a_sack = 1'b0; a_we = '0; a_io = '0;

        // round robin, four masters always requesting, slave acks immediately
        b_acc = 4'hF; b_sack = 1'b1;
        pat = '0; gseq = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            @(negedge clk);
            pat[k-1] = b_sacc;
            if (b_sacc) gseq = {gseq[7:0], b_grant};
        end
        chk("rr_bubble_pattern", pat, 9'h155);
        chk("rr_grant_order", gseq, 10'h06C);
        tick();
        b_sack = 1'b0;
        tick();
        @(negedge clk);
        chk("rr_pending_grant", {b_grant, b_mack}, 6'b01_0000);
        tick();
        reset = 1'b1; b_sack = 1'b1;
        @(negedge clk);
        chk("abort_no_ack", {b_sacc, b_mack}, 5'b0_0000);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", {b_sacc, b_mack}, 5'b0_0000);
        tick();
        @(negedge clk);
        chk("ptr_cleared", {b_grant, b_mack}, 6'b00_0001);
        tick();
        b_acc = 4'h0; b_sack = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
